// File: rtl/pipelined_barrel.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_barrel
//  Description : Two-stage pipelined barrel shifter (LSL/LSR/ASR/ROR/ROL)
//                with carry-out and zero flags and valid/ready handshakes
//                on both the operand and the result side.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipelined_barrel #(
  parameter int WIDTH = 16,
  parameter int SW    = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       shift_type,
  input  logic [SW-1:0]    shift,
  input  logic [WIDTH-1:0] data_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             carry_out,
  output logic             zero
);

  // The shift amount is split into a coarse part (upper bits, applied in
  // stage 1) and a residual part (lower bits, applied in stage 2).
  localparam int c_LO_BITS = SW / 2;
  localparam int c_HI_BITS = SW - c_LO_BITS;

  localparam logic [2:0] c_OP_LSL = 3'b000;
  localparam logic [2:0] c_OP_LSR = 3'b001;
  localparam logic [2:0] c_OP_ASR = 3'b010;
  localparam logic [2:0] c_OP_ROR = 3'b011;
  localparam logic [2:0] c_OP_ROL = 3'b100;

  // One shift step of the requested kind. Rotations use a doubled copy of
  // the operand so no wrap-around arithmetic on the amount is needed.
  // Unknown op codes pass the operand through unchanged.
  function automatic logic [WIDTH-1:0] f_shift(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] d,
    input logic [SW-1:0]    amt
  );
    logic [2*WIDTH-1:0] dd;
    logic [2*WIDTH-1:0] rr;
    logic [WIDTH-1:0]   res;
    dd  = {d, d};
    rr  = '0;
    res = d;
    case (op)
      c_OP_LSL: res = d << amt;
      c_OP_LSR: res = d >> amt;
      c_OP_ASR: res = $unsigned($signed(d) >>> amt);
      c_OP_ROR: begin
        rr  = dd >> amt;
        res = rr[WIDTH-1:0];
      end
      c_OP_ROL: begin
        rr  = dd << amt;
        res = rr[2*WIDTH-1:WIDTH];
      end
      default:  res = d;
    endcase
    return res;
  endfunction

  // Pipeline state
  logic                 r_s1_valid;
  logic [2:0]           r_s1_op;
  logic [WIDTH-1:0]     r_s1_data;
  logic [c_LO_BITS-1:0] r_s1_fine;
  logic                 r_s1_carry;

  logic                 r_s2_valid;
  logic [WIDTH-1:0]     r_data_out;
  logic                 r_carry_out;
  logic                 r_zero;

  // Combinational helpers
  logic                 w_en1;
  logic                 w_en2;
  logic [SW-1:0]        w_coarse_amt;
  logic [WIDTH-1:0]     w_coarse_data;
  logic [SW-1:0]        w_fine_amt;
  logic [WIDTH-1:0]     w_fine_data;
  logic [SW-1:0]        w_idx_hi;
  logic [SW-1:0]        w_idx_lo;
  logic                 w_carry;

  // A stage advances when it is empty or its downstream neighbour advances.
  assign w_en2    = !r_s2_valid || out_ready;
  assign w_en1    = !r_s1_valid || w_en2;
  assign in_ready = w_en1;

  // Coarse amount keeps only the upper bits; residual is zero-extended.
  assign w_coarse_amt  = {shift[SW-1:c_LO_BITS], {c_LO_BITS{1'b0}}};
  assign w_coarse_data = f_shift(shift_type, data_in, w_coarse_amt);
  assign w_fine_amt    = {{c_HI_BITS{1'b0}}, r_s1_fine};
  assign w_fine_data   = f_shift(r_s1_op, r_s1_data, w_fine_amt);

  // Bit positions of the last bit shifted out: WIDTH-n (left moves) and
  // n-1 (right moves), both taken modulo WIDTH; only used when n != 0.
  assign w_idx_hi = SW'(0) - shift;
  assign w_idx_lo = shift - SW'(1);

  // Carry is fully determined by the original operand and the whole amount,
  // so it is resolved in stage 1. ROR's result MSB and ROL's result LSB are
  // the same bits as data_in[n-1] and data_in[WIDTH-n] respectively.
  always_comb begin
    w_carry = 1'b0;
    if (shift != '0) begin
      case (shift_type)
        c_OP_LSL, c_OP_ROL:           w_carry = data_in[w_idx_hi];
        c_OP_LSR, c_OP_ASR, c_OP_ROR: w_carry = data_in[w_idx_lo];
        default:                      w_carry = 1'b0;
      endcase
    end
  end

  // Stage-1 valid bit follows the offered operand whenever the stage advances.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
    end else if (w_en1) begin
      r_s1_valid <= in_valid;
    end
  end

  // Stage-1 payload; its contents are irrelevant while the valid bit is low.
  always_ff @(posedge clock) begin
    if (w_en1) begin
      r_s1_op    <= shift_type;
      r_s1_data  <= w_coarse_data;
      r_s1_fine  <= shift[c_LO_BITS-1:0];
      r_s1_carry <= w_carry;
    end
  end

  // Stage 2 finishes the shift and registers the result with its flags;
  // holding w_en2 low during a stall keeps all outputs bit-stable.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s2_valid  <= 1'b0;
      r_data_out  <= '0;
      r_carry_out <= 1'b0;
      r_zero      <= 1'b0;
    end else if (w_en2) begin
      r_s2_valid  <= r_s1_valid;
      r_data_out  <= w_fine_data;
      r_carry_out <= r_s1_carry;
      r_zero      <= (w_fine_data == '0);
    end
  end

  assign out_valid = r_s2_valid;
  assign data_out  = r_data_out;
  assign carry_out = r_carry_out;
  assign zero      = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_barrel.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipelined_barrel
//  Description : Self-checking bench for pipelined_barrel (WIDTH 16 and 32).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_barrel;

  typedef struct {
    logic [15:0] d;
    logic        c;
    logic        z;
    int          acc;
  } exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  sh;
    logic [15:0] din;
    logic [15:0] ed;
    logic        ec;
    logic        ez;
  } vec_t;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  shift_type;
  logic [3:0]  shift;
  logic [15:0] data_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] data_out;
  logic        carry_out;
  logic        zero;

  logic        iv32;
  logic        ir32;
  logic [2:0]  st32;
  logic [4:0]  sh32;
  logic [31:0] d32;
  logic        ov32;
  logic        ordy32;
  logic [31:0] do32;
  logic        co32;
  logic        z32;

  int          compared;
  int          mismatched;
  int          cyc;
  int          n_out;
  logic        lat_check;
  logic        holding;
  logic [15:0] hold_d;
  logic        hold_c;
  logic        hold_z;
  exp_t        sb[$];
  vec_t        vecs[10];

  pipelined_barrel #(.WIDTH(16)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .shift_type(shift_type), .shift(shift), .data_in(data_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .carry_out(carry_out), .zero(zero)
  );

  pipelined_barrel #(.WIDTH(32)) dut32 (
    .clock(clock), .reset(reset),
    .in_valid(iv32), .in_ready(ir32),
    .shift_type(st32), .shift(sh32), .data_in(d32),
    .out_valid(ov32), .out_ready(ordy32),
    .data_out(do32), .carry_out(co32), .zero(z32)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: each result bit taken straight from the operation's definition.
  function automatic exp_t model(input logic [2:0] op, input int n, input logic [15:0] d);
    exp_t e;
    logic [15:0] r;
    logic c;
    r = d;
    c = 1'b0;
    if (n != 0 && op <= 3'd4) begin
      for (int i = 0; i < 16; i++) begin
        case (op)
          3'd0: r[i] = (i >= n) ? d[(i - n) & 15] : 1'b0;
          3'd1: r[i] = (i + n < 16) ? d[(i + n) & 15] : 1'b0;
          3'd2: r[i] = (i + n < 16) ? d[(i + n) & 15] : d[15];
          3'd3: r[i] = d[(i + n) % 16];
          default: r[i] = d[(i - n + 16) % 16];
        endcase
      end
      case (op)
        3'd0: c = d[16 - n];
        3'd1, 3'd2: c = d[n - 1];
        3'd3: c = r[15];
        default: c = r[0];
      endcase
    end
    e.d = r;
    e.c = c;
    e.z = (r == 16'h0);
    e.acc = 0;
    return e;
  endfunction

  // One clock cycle: drive at negedge, check just before the next posedge.
  task automatic step(input logic v, input logic [2:0] op, input logic [3:0] sh,
                      input logic [15:0] d, input logic ordy, input logic use_tab,
                      input logic [15:0] td, input logic tc, input logic tz);
    exp_t e;
    @(negedge clock);
    in_valid = v; shift_type = op; shift = sh; data_in = d; out_ready = ordy;
    #4;
    if (holding) begin
      chk("stall valid", {31'd0, out_valid}, 32'd1);
      chk("stall data", {16'd0, data_out}, {16'd0, hold_d});
      chk("stall carry", {31'd0, carry_out}, {31'd0, hold_c});
      chk("stall zero", {31'd0, zero}, {31'd0, hold_z});
    end
    holding = out_valid && !out_ready;
    hold_d = data_out; hold_c = carry_out; hold_z = zero;
    if (out_valid && out_ready) begin
      n_out++;
      if (sb.size() == 0) begin
        compared++; mismatched++;
        $display("FAIL unexpected result: got 0x%0h, required none", data_out);
      end else begin
        e = sb.pop_front();
        chk("data_out", {16'd0, data_out}, {16'd0, e.d});
        chk("carry_out", {31'd0, carry_out}, {31'd0, e.c});
        chk("zero", {31'd0, zero}, {31'd0, e.z});
        if (lat_check) chk("latency", cyc - e.acc, 32'd2);
      end
    end
    if (in_valid && in_ready) begin
      if (use_tab) begin
        e.d = td; e.c = tc; e.z = tz;
      end else begin
        e = model(op, int'(sh), d);
      end
      e.acc = cyc;
      sb.push_back(e);
    end
    cyc++;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      step(1'b0, 3'd0, 4'd0, 16'd0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0);
      guard++;
    end
    chk("drain empty", sb.size(), 32'd0);
    step(1'b0, 3'd0, 4'd0, 16'd0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0);
  endtask

  initial begin
    int nbase;
    int idx32;
    logic [31:0] e32d[2];
    compared = 0; mismatched = 0; cyc = 0; n_out = 0;
    lat_check = 1'b0; holding = 1'b0;
    hold_d = '0; hold_c = 1'b0; hold_z = 1'b0;
    reset = 1'b1;
    in_valid = 1'b0; shift_type = '0; shift = '0; data_in = '0; out_ready = 1'b1;
    iv32 = 1'b0; st32 = '0; sh32 = '0; d32 = '0; ordy32 = 1'b1;

    vecs[0] = '{3'd0, 4'd2,  16'h0001, 16'h0004, 1'b0, 1'b0};
    vecs[1] = '{3'd1, 4'd15, 16'h8000, 16'h0001, 1'b0, 1'b0};
    vecs[2] = '{3'd2, 4'd3,  16'h8000, 16'hF000, 1'b0, 1'b0};
    vecs[3] = '{3'd3, 4'd1,  16'h0001, 16'h8000, 1'b1, 1'b0};
    vecs[4] = '{3'd0, 4'd1,  16'h8000, 16'h0000, 1'b1, 1'b1};
    vecs[5] = '{3'd4, 4'd4,  16'h8001, 16'h0018, 1'b0, 1'b0};
    vecs[6] = '{3'd3, 4'd0,  16'hA5A5, 16'hA5A5, 1'b0, 1'b0};
    vecs[7] = '{3'd7, 4'd7,  16'h1234, 16'h1234, 1'b0, 1'b0};
    vecs[8] = '{3'd1, 4'd1,  16'h0003, 16'h0001, 1'b1, 1'b0};
    vecs[9] = '{3'd2, 4'd1,  16'h8001, 16'hC000, 1'b1, 1'b0};

    // Reset state while reset is held
    #12;
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset data_out", {16'd0, data_out}, 32'd0);
    chk("reset carry", {31'd0, carry_out}, 32'd0);
    chk("reset zero", {31'd0, zero}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("idle in_ready", {31'd0, in_ready}, 32'd1);

    // Directed table, streamed back-to-back with no backpressure
    lat_check = 1'b1;
    for (int i = 0; i < 10; i++)
      step(1'b1, vecs[i].op, vecs[i].sh, vecs[i].din, 1'b1, 1'b1,
           vecs[i].ed, vecs[i].ec, vecs[i].ez);
    drain();
    lat_check = 1'b0;

    // Backpressure: both stages fill, first result held, nothing lost
    nbase = n_out;
    step(1'b1, 3'd0, 4'd4, 16'h0003, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0);
    step(1'b1, 3'd1, 4'd8, 16'hF000, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 3'd3, 4'd4, 16'h1234, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
      chk("full in_ready", {31'd0, in_ready}, 32'd0);
      chk("full first data", {16'd0, data_out}, 32'h0030);
    end
    step(1'b1, 3'd3, 4'd4, 16'h1234, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0);
    step(1'b1, 3'd4, 4'd8, 16'h1234, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0);
    drain();
    chk("backpressure count", n_out - nbase, 32'd4);

    // Asynchronous reset mid-stall with two operations in flight
    step(1'b1, 3'd0, 4'd1, 16'h8001, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0);
    step(1'b1, 3'd1, 4'd2, 16'h00F0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
    step(1'b0, 3'd0, 4'd0, 16'h0000, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
    chk("pre-reset data", {16'd0, data_out}, 32'h0002);
    chk("pre-reset carry", {31'd0, carry_out}, 32'd1);
    #3;
    reset = 1'b1;
    #1;
    chk("async out_valid", {31'd0, out_valid}, 32'd0);
    chk("async data_out", {16'd0, data_out}, 32'd0);
    chk("async carry", {31'd0, carry_out}, 32'd0);
    chk("async zero", {31'd0, zero}, 32'd0);
    sb.delete();
    holding = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("post-reset in_ready", {31'd0, in_ready}, 32'd1);
    lat_check = 1'b1;
    step(1'b1, 3'd1, 4'd4, 16'h00F0, 1'b1, 1'b1, 16'h000F, 1'b0, 1'b0);
    drain();
    lat_check = 1'b0;

    // Randomized traffic with random backpressure against the model
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 4'($urandom),
           16'($urandom), $urandom_range(0, 3) != 0, 1'b0, 16'd0, 1'b0, 1'b0);
    drain();

    // 32-bit instance
    e32d[0] = 32'hFFFF_FFFF;
    e32d[1] = 32'h8000_0000;
    idx32 = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      iv32 = (k < 2);
      st32 = (k == 0) ? 3'd2 : 3'd0;
      sh32 = 5'd31;
      d32  = (k == 0) ? 32'h8000_0000 : 32'h0000_0001;
      #4;
      if (ov32) begin
        if (idx32 < 2) begin
          chk("w32 data", do32, e32d[idx32]);
          chk("w32 carry", {31'd0, co32}, 32'd0);
        end
        idx32++;
      end
    end
    chk("w32 count", idx32, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
